// File: rtl/axi_dma_burst_engine.sv
// axi_dma_burst_engine
// Single-channel AXI4 memory-to-memory copy engine. A command (src, dst, len
// in beats) is read with INCR bursts into an internal FIFO and written back
// out with INCR bursts to the destination. Bursts never cross a 4KB page.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_src/cmd_dst/cmd_len payload
//   busy, done, err            status: transfer running, completion pulse,
//                              sticky response error for the current transfer
//   ar*/r*                     AXI4 read master (AR and R channels)
//   aw*/w*/b*                  AXI4 write master (AW, W and B channels)
//   dbg_rd_state/dbg_wr_state  current read / write FSM state
//
// Handshakes: every channel transfers on a cycle where valid and ready are
// both high at the rising clock edge. A raised valid is never dropped and its
// payload never changes until that transfer happens; ready may be driven
// independently of valid. No output depends combinationally on an input.
module axi_dma_burst_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [1:0]            dbg_rd_state,
  output logic [1:0]            dbg_wr_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  // Burst arithmetic width: wide enough for cmd_len, the 4KB page room and
  // the FIFO count, plus one bit so comparisons never overflow.
  localparam int BW0   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam int BW    = ((BW0 > CW) ? BW0 : CW) + 1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // beats = min(MAX_BURST, remaining, beats left before the next 4KB page)
  function automatic logic [BW-1:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                                input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0]   room;
    logic [BW-1:0] b;
    logic [BW-1:0] r;
    logic [BW-1:0] m;
    room = 13'd4096 - {1'b0, a[11:0]};
    r    = BW'(room >> SIZE);
    m    = BW'(MAX_BURST);
    b    = BW'(rem);
    if (m < b) b = m;
    if (r < b) b = r;
    return b;
  endfunction

  logic [1:0]            r_state;
  logic [1:0]            w_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [LEN_WIDTH-1:0]  rd_rem;
  logic [LEN_WIDTH-1:0]  wr_rem;
  logic [BW-1:0]         rd_beats;
  logic [BW-1:0]         wr_beats;
  logic [7:0]            wbeat;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         fifo_free;

  logic cmd_fire;
  logic push;
  logic pop;
  logic b_fire;

  assign arsize    = 3'(SIZE);
  assign awsize    = 3'(SIZE);
  assign arburst   = 2'b01;
  assign awburst   = 2'b01;

  assign cmd_ready = !busy;
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign arvalid   = (r_state == R_ADDR);
  assign rready    = (r_state == R_DATA);
  assign awvalid   = (w_state == W_ADDR);
  assign wvalid    = (w_state == W_DATA) && (count != '0);
  assign wlast     = wvalid && (wbeat == awlen);
  assign wdata     = mem[rd_ptr];
  assign bready    = (w_state == W_RESP);

  assign push      = rvalid && rready;
  assign pop       = wvalid && wready;
  assign b_fire    = bvalid && bready;

  assign fifo_free = CW'(FIFO_DEPTH) - count;
  assign rd_beats  = burst_beats(rd_addr, rd_rem);
  assign wr_beats  = burst_beats(wr_addr, wr_rem);

  assign dbg_rd_state = r_state;
  assign dbg_wr_state = w_state;

  // Command / status. A zero-length command never raises busy; it only
  // produces the done pulse on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_fire) begin
        busy <= (cmd_len != '0);
        done <= (cmd_len == '0);
        err  <= 1'b0;
      end else begin
        if ((push && rresp != 2'b00) || (b_fire && bresp != 2'b00))
          err <= 1'b1;
        // wr_rem was already reduced when the final AW was prepared, so a
        // B handshake with nothing left to write closes the transfer.
        if (b_fire && wr_rem == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // Read side. Space for a whole burst is reserved before AR is raised, so
  // the single outstanding burst can always be absorbed by the FIFO. After
  // each burst the FSM passes through R_IDLE to re-check space.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      araddr  <= '0;
      arlen   <= '0;
      rd_addr <= '0;
      rd_rem  <= '0;
    end else begin
      if (cmd_fire) begin
        rd_addr <= cmd_src;
        rd_rem  <= cmd_len;
      end
      case (r_state)
        R_IDLE: begin
          if (busy && rd_rem != '0 && BW'(fifo_free) >= rd_beats) begin
            araddr  <= rd_addr;
            arlen   <= 8'(rd_beats - 1'b1);
            rd_addr <= rd_addr + (ADDR_WIDTH'(rd_beats) << SIZE);
            rd_rem  <= rd_rem - LEN_WIDTH'(rd_beats);
            r_state <= R_ADDR;
          end
        end
        R_ADDR: if (arready) r_state <= R_DATA;
        R_DATA: if (rvalid && rlast) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write side. A burst starts only once all of its beats sit in the FIFO,
  // so W never stalls on an empty FIFO mid-burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awaddr  <= '0;
      awlen   <= '0;
      wr_addr <= '0;
      wr_rem  <= '0;
      wbeat   <= '0;
    end else begin
      if (cmd_fire) begin
        wr_addr <= cmd_dst;
        wr_rem  <= cmd_len;
      end
      case (w_state)
        W_IDLE: begin
          if (busy && wr_rem != '0 && BW'(count) >= wr_beats) begin
            awaddr  <= wr_addr;
            awlen   <= 8'(wr_beats - 1'b1);
            wr_addr <= wr_addr + (ADDR_WIDTH'(wr_beats) << SIZE);
            wr_rem  <= wr_rem - LEN_WIDTH'(wr_beats);
            w_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          wbeat <= '0;
          if (awready) w_state <= W_DATA;
        end
        W_DATA: begin
          if (pop) begin
            if (wbeat == awlen) w_state <= W_RESP;
            else                wbeat   <= wbeat + 8'd1;
          end
        end
        W_RESP: if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // FIFO storage: no reset needed, only the pointers and count matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_dma_burst_engine.sv
// Bench for axi_dma_burst_engine: behavioural AXI read/write slaves, a write
// data scoreboard (exp_q) and directed scenario tasks.
module tb_axi_dma_burst_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_q = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_dst = '0;
  logic [15:0] cmd_len = '0;
  logic        busy, done, err;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic        arvalid, awvalid;
  logic        arready, awready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [1:0]  dbg_rd_state, dbg_wr_state;

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;

  axi_dma_burst_engine dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ar_addr_log[$];
  logic [7:0]  ar_len_log[$];
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];

  // slave configuration
  bit ar_en = 1'b1, aw_en = 1'b1, w_en = 1'b1, r_gap = 1'b0, w_gap = 1'b0;
  int b_err_idx = -1;
  int r_err_at = -1;

  // slave state and statistics
  logic [31:0] rq_addr[$];
  logic [7:0]  rq_len[$];
  logic [7:0]  awq_len[$];
  bit          r_act = 1'b0, w_act = 1'b0;
  logic [31:0] r_addr = '0;
  int          r_left = 0, w_beat = 0, w_len = 0, b_pend = 0, b_cnt = 0;
  int          r_beats_total = 0, w_beats_total = 0, done_count = 0, cyc = 0;
  logic        err_at_done = 1'b0, busy_at_done = 1'b0;
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic [31:0] ar_a, aw_a, w_d;
  logic [7:0]  ar_l, aw_l;
  logic        w_l;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Slaves work on the falling edge: apply the handshakes seen at the last
  // rising edge, drive new inputs, then note which handshakes the next
  // rising edge will take.
  initial begin : slaves
    logic [31:0] e;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        done_count++;
        err_at_done = err;
        busy_at_done = busy;
      end
      if (rst_q) begin
        rq_addr.delete(); rq_len.delete(); awq_len.delete(); exp_q.delete();
        r_act = 0; w_act = 0; b_pend = 0;
      end else begin
        if (ar_hs) begin
          ar_addr_log.push_back(ar_a); ar_len_log.push_back(ar_l);
          rq_addr.push_back(ar_a); rq_len.push_back(ar_l);
        end
        if (r_hs) begin
          r_beats_total++; r_addr += 32'd4; r_left--;
          if (r_left == 0) r_act = 0;
        end
        if (aw_hs) begin
          aw_addr_log.push_back(aw_a); aw_len_log.push_back(aw_l);
          awq_len.push_back(aw_l);
        end
        if (w_hs) begin
          w_beats_total++;
          checks++;
          if (!w_act) begin
            failures++;
            $display("FAIL w_without_aw got=beat %h expected=no W beat", w_d);
          end else begin
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL wdata got=%h expected=<no more data>", w_d);
            end else begin
              e = exp_q.pop_front();
              if (w_d !== e) begin
                failures++;
                $display("FAIL wdata got=%h expected=%h", w_d, e);
              end
            end
            checks++;
            if (w_l !== (w_beat == w_len)) begin
              failures++;
              $display("FAIL wlast beat=%0d got=%b expected=%b", w_beat, w_l, (w_beat == w_len));
            end
            w_beat++;
            if (w_beat > w_len) begin w_act = 0; b_pend++; end
          end
        end
        if (b_hs) begin b_cnt++; b_pend--; end
        if (!w_act && awq_len.size() > 0) begin
          w_len = int'(awq_len.pop_front()); w_beat = 0; w_act = 1;
        end
        if (!r_act && rq_addr.size() > 0) begin
          r_addr = rq_addr.pop_front(); r_left = int'(rq_len.pop_front()) + 1; r_act = 1;
        end
      end
      arready = ar_en;
      awready = aw_en;
      wready  = w_en && !(w_gap && cyc[1]);
      rvalid  = r_act && !(r_gap && cyc[0]);
      rdata   = pat(r_addr);
      rlast   = r_act && (r_left == 1);
      rresp   = (r_beats_total == r_err_at) ? 2'b10 : 2'b00;
      bvalid  = (b_pend > 0);
      bresp   = (b_cnt == b_err_idx) ? 2'b10 : 2'b00;
      ar_hs = arvalid && arready; ar_a = araddr; ar_l = arlen;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready; aw_a = awaddr; aw_l = awlen;
      w_hs  = wvalid && wready; w_d = wdata; w_l = wlast;
      b_hs  = bvalid && bready;
    end
  end

  task automatic clear_logs();
    ar_addr_log.delete(); ar_len_log.delete();
    aw_addr_log.delete(); aw_len_log.delete();
  endtask

  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst, input int len);
    @(negedge clk);
    for (int i = 0; i < len; i++) exp_q.push_back(pat(src + 32'(4 * i)));
    cmd_src = src; cmd_dst = dst; cmd_len = 16'(len); cmd_valid = 1'b1;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit ok);
    for (int i = 0; i < 4000 && done_count == base; i++) @(negedge clk);
    ok = (done_count != base);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, arvalid, awvalid, wvalid, wlast, rready, bready} !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL reset_ctl got=%b expected=1000000000",
               {cmd_ready, busy, done, err, arvalid, awvalid, wvalid, wlast, rready, bready});
    end
    checks++;
    if ({araddr, awaddr, arlen, awlen} !== 80'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h expected=0", {araddr, awaddr, arlen, awlen});
    end
    checks++;
    if ({arburst, awburst, arsize, awsize} !== {2'b01, 2'b01, 3'd2, 3'd2}) begin
      failures++;
      $display("FAIL reset_const got=%b expected=%b", {arburst, awburst, arsize, awsize},
               {2'b01, 2'b01, 3'd2, 3'd2});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst();
    int d0; bit ok;
    clear_logs(); d0 = done_count;
    send_cmd(32'h1000, 32'h2000, 16);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done_timeout got=no done expected=done"); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_count != d0 + 1) begin
      failures++; $display("FAIL single_done_count got=%0d expected=%0d", done_count - d0, 1);
    end
    checks++;
    if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 32'h1000 || ar_len_log[0] !== 8'd15) begin
      failures++; $display("FAIL single_ar got n=%0d expected n=1 addr=1000 len=15", ar_addr_log.size());
    end
    checks++;
    if (aw_addr_log.size() != 1 || aw_addr_log[0] !== 32'h2000 || aw_len_log[0] !== 8'd15) begin
      failures++; $display("FAIL single_aw got n=%0d expected n=1 addr=2000 len=15", aw_addr_log.size());
    end
    checks++;
    if (err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL single_status got err=%b busy=%b expected err=0 busy=0", err_at_done, busy_at_done);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL single_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_multi_burst();
    int d0; bit ok;
    logic [31:0] ea[3]; logic [31:0] wa[3]; logic [7:0] el[3];
    ea = '{32'h1000, 32'h1040, 32'h1080};
    wa = '{32'h2000, 32'h2040, 32'h2080};
    el = '{8'd15, 8'd15, 8'd7};
    clear_logs(); d0 = done_count;
    r_gap = 1'b1; w_gap = 1'b1;
    send_cmd(32'h1000, 32'h2000, 40);
    wait_done(d0, ok);
    r_gap = 1'b0; w_gap = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL multi_done_timeout got=no done expected=done"); end
    checks++;
    if (ar_addr_log.size() != 3 || aw_addr_log.size() != 3) begin
      failures++; $display("FAIL multi_counts got ar=%0d aw=%0d expected 3/3", ar_addr_log.size(), aw_addr_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < ar_addr_log.size() && i < aw_addr_log.size()) begin
        checks++;
        if (ar_addr_log[i] !== ea[i] || ar_len_log[i] !== el[i] ||
            aw_addr_log[i] !== wa[i] || aw_len_log[i] !== el[i]) begin
          failures++;
          $display("FAIL multi_burst%0d got ar=%h/%0d aw=%h/%0d expected ar=%h/%0d aw=%h/%0d", i,
                   ar_addr_log[i], ar_len_log[i], aw_addr_log[i], aw_len_log[i], ea[i], el[i], wa[i], el[i]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL multi_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_4k_split();
    int d0; bit ok;
    logic [31:0] ea[2]; logic [7:0] el[2]; logic [31:0] wa[2]; logic [7:0] wl[2];
    ea = '{32'h0FF0, 32'h1000}; el = '{8'd3, 8'd11};
    wa = '{32'h3FF8, 32'h4000}; wl = '{8'd1, 8'd13};
    clear_logs(); d0 = done_count;
    send_cmd(32'h0FF0, 32'h3FF8, 16);
    wait_done(d0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL split_done_timeout got=no done expected=done"); end
    checks++;
    if (ar_addr_log.size() != 2 || aw_addr_log.size() != 2) begin
      failures++; $display("FAIL split_counts got ar=%0d aw=%0d expected 2/2", ar_addr_log.size(), aw_addr_log.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < ar_addr_log.size()) begin
        checks++;
        if (ar_addr_log[i] !== ea[i] || ar_len_log[i] !== el[i]) begin
          failures++; $display("FAIL split_ar%0d got=%h/%0d expected=%h/%0d", i, ar_addr_log[i], ar_len_log[i], ea[i], el[i]);
        end
      end
      if (i < aw_addr_log.size()) begin
        checks++;
        if (aw_addr_log[i] !== wa[i] || aw_len_log[i] !== wl[i]) begin
          failures++; $display("FAIL split_aw%0d got=%h/%0d expected=%h/%0d", i, aw_addr_log[i], aw_len_log[i], wa[i], wl[i]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL split_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int d0, rb, wb; bit ok;
    clear_logs(); d0 = done_count; rb = r_beats_total; wb = w_beats_total;
    w_en = 1'b0;
    send_cmd(32'h1000, 32'h2000, 64);
    repeat (200) @(negedge clk);
    checks++;
    if (r_beats_total - rb != 32) begin
      failures++; $display("FAIL bp_fill got=%0d expected=32", r_beats_total - rb);
    end
    checks++;
    if (arvalid !== 1'b0 || ar_addr_log.size() != 2) begin
      failures++; $display("FAIL bp_ar_hold got arvalid=%b ar_n=%0d expected arvalid=0 ar_n=2", arvalid, ar_addr_log.size());
    end
    checks++;
    if (w_beats_total != wb) begin failures++; $display("FAIL bp_no_w got=%0d expected=0", w_beats_total - wb); end
    w_en = 1'b1;
    wait_done(d0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done_timeout got=no done expected=done"); end
    checks++;
    if (ar_addr_log.size() != 4 || aw_addr_log.size() != 4 || w_beats_total - wb != 64) begin
      failures++; $display("FAIL bp_totals got ar=%0d aw=%0d w=%0d expected 4/4/64",
                           ar_addr_log.size(), aw_addr_log.size(), w_beats_total - wb);
    end
    checks++;
    if (exp_q.size() != 0 || err_at_done !== 1'b0) begin
      failures++; $display("FAIL bp_end got left=%0d err=%b expected left=0 err=0", exp_q.size(), err_at_done);
    end
  endtask

  task automatic test_bresp_err();
    int d0; bit ok;
    clear_logs(); d0 = done_count;
    b_err_idx = b_cnt;
    send_cmd(32'h1000, 32'h2000, 32);
    wait_done(d0, ok);
    b_err_idx = -1;
    checks++;
    if (!ok) begin failures++; $display("FAIL berr_done_timeout got=no done expected=done"); end
    checks++;
    if (err_at_done !== 1'b1 || aw_addr_log.size() != 2) begin
      failures++; $display("FAIL berr_status got err=%b aw=%0d expected err=1 aw=2", err_at_done, aw_addr_log.size());
    end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL berr_sticky got=%b expected=1", err); end
    // zero-length command: clears err, no bus traffic, done next cycle
    clear_logs(); d0 = done_count;
    send_cmd(32'h1000, 32'h2000, 0);
    wait_done(d0, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || done_count != d0 + 1) begin
      failures++; $display("FAIL zero_done got=%0d expected=1", done_count - d0);
    end
    checks++;
    if (err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
      failures++; $display("FAIL zero_status got err=%b busy=%b expected err=0 busy=0", err_at_done, busy_at_done);
    end
    checks++;
    if (ar_addr_log.size() != 0 || aw_addr_log.size() != 0) begin
      failures++; $display("FAIL zero_traffic got ar=%0d aw=%0d expected 0/0", ar_addr_log.size(), aw_addr_log.size());
    end
  endtask

  task automatic test_rresp_err();
    int d0; bit ok;
    clear_logs(); d0 = done_count;
    r_err_at = r_beats_total + 3;
    send_cmd(32'h0500, 32'h0900, 8);
    wait_done(d0, ok);
    r_err_at = -1;
    checks++;
    if (!ok || err_at_done !== 1'b1) begin
      failures++; $display("FAIL rerr_status got done=%b err=%b expected done=1 err=1", ok, err_at_done);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rerr_left got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d0, rb; bit ok;
    clear_logs(); d0 = done_count; rb = r_beats_total;
    send_cmd(32'h1000, 32'h2000, 48);
    for (int i = 0; i < 500 && r_beats_total < rb + 5; i++) @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin failures++; $display("FAIL mid_in_rdata got rready=%b expected=1", rready); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, arvalid, awvalid, wvalid, wlast, rready, bready} !== 10'b10_0000_0000) begin
      failures++;
      $display("FAIL mid_reset_ctl got=%b expected=1000000000",
               {cmd_ready, busy, done, err, arvalid, awvalid, wvalid, wlast, rready, bready});
    end
    checks++;
    if ({araddr, awaddr, arlen, awlen} !== 80'h0) begin
      failures++; $display("FAIL mid_reset_addr got=%h expected=0", {araddr, awaddr, arlen, awlen});
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (done_count != d0) begin failures++; $display("FAIL mid_no_done got=%0d expected=0", done_count - d0); end
    clear_logs();
    send_cmd(32'h1000, 32'h2000, 16);
    wait_done(d0, ok);
    checks++;
    if (!ok || err_at_done !== 1'b0) begin
      failures++; $display("FAIL after_reset_done got done=%b err=%b expected done=1 err=0", ok, err_at_done);
    end
    checks++;
    if (ar_addr_log.size() != 1 || aw_addr_log.size() != 1 || exp_q.size() != 0) begin
      failures++; $display("FAIL after_reset_bursts got ar=%0d aw=%0d left=%0d expected 1/1/0",
                           ar_addr_log.size(), aw_addr_log.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_split();
    test_backpressure();
    test_bresp_err();
    test_rresp_err();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
